// File: rtl/board_load_ctrl_if.sv
// Bundles the three buses that meet at the board loader.
// Latency: none; this is wiring only.
// Backpressure: the game write request is held by its owner until it sees game_wr_ack.
//
// Signal groups:
//   colour generator : cc_enable (to generator), cc_address / cc_data (from generator)
//   game write port  : game_wr_req / game_wr_addr / game_wr_data (in), game_wr_ack (out)
//   regfile write    : rf_we / rf_waddr / rf_wdata (to regfile)
// The slave modport is the loader's view; the master modport is the surrounding system's view.
interface board_load_ctrl_if;
    // colour generator
    logic        cc_enable;
    logic [3:0]  cc_address;
    logic [13:0] cc_data;

    // game logic write request
    logic        game_wr_req;
    logic [3:0]  game_wr_addr;
    logic [13:0] game_wr_data;
    logic        game_wr_ack;

    // register file write port
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [13:0] rf_wdata;

    modport slave (
        output cc_enable,
        input  cc_address,
        input  cc_data,
        input  game_wr_req,
        input  game_wr_addr,
        input  game_wr_data,
        output game_wr_ack,
        output rf_we,
        output rf_waddr,
        output rf_wdata
    );

    modport master (
        input  cc_enable,
        output cc_address,
        output cc_data,
        output game_wr_req,
        output game_wr_addr,
        output game_wr_data,
        input  game_wr_ack,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata
    );
endinterface

// File: rtl/board_load_ctrl.sv
// Board loader: streams NUM_CARDS generator words into regfile 1..NUM_CARDS, then writes the header to 0.
// Latency: first card on rf 2 cycles after new_game is sampled, header after NUM_CARDS+2, board_ready after NUM_CARDS+3.
// Backpressure: game writes are acked only in IDLE/READY; during LOAD/HDR the requester must hold its request.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   new_game       start-load pulse from the game FSM (ignored while busy)
//   bus            board_load_ctrl_if.slave: generator, game write request and regfile write port
//   busy           high while loading cards or writing the header
//   board_ready    high once the board is fully written
//
// NUM_CARDS must be even and at most 15 so that all card addresses fit in 4 bits next to header address 0.
module board_load_ctrl #(
    parameter int NUM_CARDS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    board_load_ctrl_if.slave bus,
    output logic             busy,
    output logic             board_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        HDR   = 2'd2,
        READY = 2'd3
    } state_t;

    // Counter value on the last enable cycle; enable drops at the edge that sees it.
    localparam logic [3:0]  LAST_CNT = 4'(NUM_CARDS - 1);
    // Header word: number of card pairs on the board.
    localparam logic [13:0] HDR_WORD = 14'(NUM_CARDS / 2);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        cc_enable_q;
    logic        valid_q;
    logic        rf_we_q;
    logic [3:0]  rf_waddr_q;
    logic [13:0] rf_wdata_q;
    logic        busy_q;
    logic        board_ready_q;

    // The regfile port belongs to the game logic only while no load is in flight,
    // so loader and game writes can never collide and no priority scheme is needed.
    logic game_grant;
    assign game_grant      = (state_q == IDLE) || (state_q == READY);
    assign bus.game_wr_ack = game_grant && bus.game_wr_req;

    assign bus.cc_enable = cc_enable_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign busy          = busy_q;
    assign board_ready   = board_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            cc_enable_q   <= 1'b0;
            valid_q       <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= 4'd0;
            rf_wdata_q    <= 14'd0;
            busy_q        <= 1'b0;
            board_ready_q <= 1'b0;
        end else begin
            // The generator presents a word one cycle after each enable cycle,
            // so the enable delayed by one flop marks a valid cc_address/cc_data pair.
            valid_q <= cc_enable_q;
            rf_we_q <= 1'b0;

            case (state_q)
                IDLE, READY: begin
                    if (bus.game_wr_req) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= bus.game_wr_addr;
                        rf_wdata_q <= bus.game_wr_data;
                    end
                    // board_ready rises one cycle after entering READY, i.e. after
                    // the header write is already visible on the regfile outputs.
                    board_ready_q <= (state_q == READY) && !new_game;
                    if (new_game) begin
                        state_q     <= LOAD;
                        cnt_q       <= 4'd0;
                        cc_enable_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                LOAD: begin
                    // Enable stays high for exactly NUM_CARDS cycles (counter 0..NUM_CARDS-1).
                    if (cc_enable_q) begin
                        if (cnt_q == LAST_CNT) begin
                            cc_enable_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    if (valid_q) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= bus.cc_address;
                        rf_wdata_q <= bus.cc_data;
                        // Valid word with enable already low: this is the last card.
                        if (!cc_enable_q) begin
                            state_q <= HDR;
                        end
                    end
                end

                HDR: begin
                    rf_we_q       <= 1'b1;
                    rf_waddr_q    <= 4'd0;
                    rf_wdata_q    <= HDR_WORD;
                    busy_q        <= 1'b0;
                    board_ready_q <= 1'b0;
                    state_q       <= READY;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_load_ctrl.sv
`timescale 1ns/1ps
module tb_board_load_ctrl;

    localparam int N = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic        busy;
    logic        board_ready;
    logic        req;
    logic [3:0]  wa;
    logic [13:0] wd;

    board_load_ctrl_if bus();

    board_load_ctrl #(.NUM_CARDS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .bus         (bus),
        .busy        (busy),
        .board_ready (board_ready)
    );

    always #5 clk = ~clk;

    assign bus.game_wr_req  = req;
    assign bus.game_wr_addr = wa;
    assign bus.game_wr_data = wd;

    // Colour generator: advances one word per enabled cycle, addresses 1..N, restarts on rst.
    logic [3:0]  gen_a;
    logic [11:0] gen_col [0:15];
    always @(posedge clk) begin
        if (rst) gen_a <= 4'd0;
        else if (bus.cc_enable) gen_a <= (gen_a == 4'(N)) ? 4'd1 : gen_a + 4'd1;
    end
    assign bus.cc_address = gen_a;
    assign bus.cc_data    = {gen_col[gen_a], 2'b01};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: timeline of a load measured from the edge that started it.
    int          t_edge = 0;
    int          m_e0   = -1;
    int          d;
    logic        busy_prev;
    logic        x_en = 1'b0, x_we = 1'b0, x_busy = 1'b0, x_rdy = 1'b0;
    logic [3:0]  x_wa;
    logic [13:0] x_wd;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        busy_prev = (m_e0 >= 0) && (t_edge - m_e0 <= N + 1);
        t_edge++;
        if (rst) begin
            m_e0 = -1;
            x_en = 0; x_we = 0; x_wa = 0; x_wd = 0; x_busy = 0; x_rdy = 0;
        end else begin
            if (new_game && !busy_prev) m_e0 = t_edge;
            d = (m_e0 >= 0) ? t_edge - m_e0 : -1;
            x_en   = (d >= 0) && (d <= N - 1);
            x_busy = (d >= 0) && (d <= N + 1);
            x_rdy  = (d >= N + 3);
            if (req && !busy_prev) begin
                x_we = 1; x_wa = wa; x_wd = wd;
            end else if (d >= 2 && d <= N + 1) begin
                x_we = 1; x_wa = 4'(d - 1); x_wd = {gen_col[d - 1], 2'b01};
            end else if (d == N + 2) begin
                x_we = 1; x_wa = 4'd0; x_wd = 14'(N / 2);
            end else begin
                x_we = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            chk("m_en",   bus.cc_enable, x_en);
            chk("m_we",   bus.rf_we, x_we);
            chk("m_busy", busy, x_busy);
            chk("m_rdy",  board_ready, x_rdy);
            chk("m_ack",  bus.game_wr_ack, req && !x_busy);
            if (x_we) begin
                chk("m_wa", bus.rf_waddr, x_wa);
                chk("m_wd", bus.rf_wdata, x_wd);
            end
        end
    end

    // Vector table: inputs for one cycle, ack in that cycle, outputs after the edge.
    typedef struct packed {
        logic        rst;
        logic        ng;
        logic        req;
        logic [3:0]  wa;
        logic [13:0] wd;
        logic        x_ack;
        logic        x_en;
        logic        x_we;
        logic [3:0]  x_wa;
        logic [13:0] x_wd;
        logic        x_busy;
        logic        x_rdy;
    } vec_t;

    localparam int NV = 24;
    vec_t tv [0:NV-1];

    function automatic vec_t mk(input logic r, input logic ng, input logic rq,
                                input logic [3:0] a, input logic [13:0] dt,
                                input logic xa, input logic xe, input logic xw,
                                input logic [3:0] xwa, input logic [13:0] xwd,
                                input logic xb, input logic xr);
        vec_t v;
        v.rst = r; v.ng = ng; v.req = rq; v.wa = a; v.wd = dt;
        v.x_ack = xa; v.x_en = xe; v.x_we = xw; v.x_wa = xwa; v.x_wd = xwd;
        v.x_busy = xb; v.x_rdy = xr;
        return v;
    endfunction

    task automatic do_load(input int ng2_cyc, input int req_cyc,
                           output int nwr, output int rdy_cyc, output int ack_cyc);
        nwr = 0; rdy_cyc = -1; ack_cyc = -1;
        @(negedge clk);
        new_game = 1'b1; req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            new_game = (c + 1 == ng2_cyc);
            req      = (req_cyc >= 0) && (c >= req_cyc);
            wa       = 4'hE;
            wd       = 14'h1EE1;
            #1;
            if (bus.rf_we && bus.rf_waddr != 4'hE) nwr++;
            if (board_ready && rdy_cyc < 0) rdy_cyc = c;
            if (bus.game_wr_ack && ack_cyc < 0) ack_cyc = c;
        end
        new_game = 1'b0; req = 1'b0;
    endtask

    initial begin
        int nwr, rdy_c, ack_c;

        rst = 1'b1; new_game = 1'b0; req = 1'b0; wa = 4'd0; wd = 14'd0;
        for (int k = 0; k < 16; k++) gen_col[k] = 12'hA00 | 12'(k);

        tv[0]  = mk(1'b1, 1'b0, 1'b1, 4'h2, 14'h0AAA, 1'b1, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b0);
        tv[1]  = mk(1'b0, 1'b0, 1'b1, 4'h3, 14'h0123, 1'b1, 1'b0, 1'b1, 4'h3, 14'h0123, 1'b0, 1'b0);
        tv[2]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0000, 1'b1, 1'b0);
        tv[3]  = mk(1'b0, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0000, 1'b1, 1'b0);
        for (int k = 1; k <= N; k++)
            tv[3 + k] = mk(1'b0, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, (k <= 10), 1'b1,
                           4'(k), {12'hA00 | 12'(k), 2'b01}, 1'b1, 1'b0);
        tv[16] = mk(1'b0, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b0, 1'b1, 4'h0, 14'h0006, 1'b0, 1'b0);
        tv[17] = mk(1'b0, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b1);
        tv[18] = mk(1'b0, 1'b1, 1'b1, 4'h5, 14'h3FFD, 1'b1, 1'b1, 1'b1, 4'h5, 14'h3FFD, 1'b1, 1'b0);
        tv[19] = mk(1'b0, 1'b0, 1'b1, 4'h5, 14'h3FFD, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0000, 1'b1, 1'b0);
        tv[20] = mk(1'b0, 1'b0, 1'b1, 4'h5, 14'h3FFD, 1'b0, 1'b1, 1'b1, 4'h1, 14'h2805, 1'b1, 1'b0);
        tv[21] = mk(1'b1, 1'b0, 1'b1, 4'h5, 14'h3FFD, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b0);
        tv[22] = mk(1'b0, 1'b0, 1'b1, 4'hF, 14'h0000, 1'b1, 1'b0, 1'b1, 4'hF, 14'h0000, 1'b0, 1'b0);
        tv[23] = mk(1'b0, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0000, 1'b0, 1'b0);

        // Reset held with random inputs: outputs stay 0, ack follows req in IDLE.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_en", bus.cc_enable, 1'b0);
            chk("rst_we", bus.rf_we, 1'b0);
            chk("rst_wa", bus.rf_waddr, 4'd0);
            chk("rst_wd", bus.rf_wdata, 14'd0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rdy", board_ready, 1'b0);
            new_game = 1'($urandom_range(0, 1));
            req      = 1'($urandom_range(0, 1));
            wa       = 4'($urandom);
            wd       = 14'($urandom);
            #1;
            chk("rst_ack", bus.game_wr_ack, req);
        end
        @(negedge clk);
        chk("rst_we_end", bus.rf_we, 1'b0);
        chk("rst_busy_end", busy, 1'b0);

        // Table: game write, full load, header, ready, collision, stall, reset.
        for (int i = 0; i < NV; i++) begin
            rst = tv[i].rst; new_game = tv[i].ng; req = tv[i].req; wa = tv[i].wa; wd = tv[i].wd;
            #1;
            chk($sformatf("t%0d_ack", i), bus.game_wr_ack, tv[i].x_ack);
            @(negedge clk);
            chk($sformatf("t%0d_en", i), bus.cc_enable, tv[i].x_en);
            chk($sformatf("t%0d_we", i), bus.rf_we, tv[i].x_we);
            chk($sformatf("t%0d_busy", i), busy, tv[i].x_busy);
            chk($sformatf("t%0d_rdy", i), board_ready, tv[i].x_rdy);
            if (tv[i].x_we || tv[i].rst) begin
                chk($sformatf("t%0d_wa", i), bus.rf_waddr, tv[i].x_wa);
                chk($sformatf("t%0d_wd", i), bus.rf_wdata, tv[i].x_wd);
            end
        end
        rst = 1'b0; new_game = 1'b0; req = 1'b0;

        // Random colours from here on; the model tracks every cycle.
        for (int k = 0; k < 16; k++) gen_col[k] = 12'($urandom);
        chk_en = 1'b1;

        // Stall: game request held from cycle 3, first ack in first READY cycle.
        do_load(-1, 3, nwr, rdy_c, ack_c);
        chk("stall_nwr", nwr, 13);
        chk("stall_rdy", rdy_c, 15);
        chk("stall_ack", ack_c, 14);

        // Ignored restart at cycle 6.
        do_load(6, -1, nwr, rdy_c, ack_c);
        chk("restart_nwr", nwr, 13);
        chk("restart_rdy", rdy_c, 15);

        // Reset at cycle 7 of a load, then a clean load.
        @(negedge clk);
        new_game = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            new_game = 1'b0;
            rst = (c == 6);
        end
        @(negedge clk);
        #1;
        chk("midrst_en", bus.cc_enable, 1'b0);
        chk("midrst_we", bus.rf_we, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        do_load(-1, -1, nwr, rdy_c, ack_c);
        chk("midrst_nwr", nwr, 13);
        chk("midrst_rdy", rdy_c, 15);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 299) == 0);
            new_game = ($urandom_range(0, 24) == 0);
            req      = 1'($urandom_range(0, 1));
            wa       = 4'($urandom);
            wd       = 14'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; new_game = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_load_ctrl.md
Name: board_load_ctrl

Overview:
- Sequences the card colour generator at the start of every game and streams its 12 card words into the card register file.
- After the stream, writes the board header word to register 0.
- Arbitrates the single register-file write port between this loader and the game logic, which uses it for flip/match updates.
- Sits between the top-level game FSM, the colour generator and the regfile write port.

Parameters:
- NUM_CARDS, 12, number of card words requested per load; regfile addresses 1..NUM_CARDS; must be even, at most 15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- new_game  in  1  start-load pulse from game FSM
- cc_address  in  4  generator address output
- cc_data  in  14  generator data output: [13:2] colour, [1] discovered, [0] active
- cc_enable  out  1  generator enable; generator advances one word per cycle while high
- game_wr_req  in  1  game logic write request
- game_wr_addr  in  4  game logic write address
- game_wr_data  in  14  game logic write data
- game_wr_ack  out  1  combinational; write accepted this cycle
- rf_we  out  1  regfile write enable, registered
- rf_waddr  out  4  regfile write address, registered
- rf_wdata  out  14  regfile write data, registered
- busy  out  1  high in LOAD and HDR
- board_ready  out  1  high in READY

Behaviour:
- Reset: state IDLE. cc_enable, rf_we, rf_waddr, rf_wdata, busy and board_ready are all 0. Word counter is 0. Valid pipe is 0.
- Reset mid-operation: same values at the next edge. The partial load is abandoned. The generator is reset by the same rst.
- States: IDLE, LOAD, HDR, READY.

IDLE and READY:
- new_game sampled high -> LOAD. Counter := 0. cc_enable := 1.
- game_wr_ack = game_wr_req; granted only in IDLE or READY.
- On ack, next edge: rf_we := 1, rf_waddr := game_wr_addr, rf_wdata := game_wr_data.
- One write per ack cycle; a request held high writes every cycle.
- No ack and no loader write -> rf_we := 0.

LOAD:
- cc_enable stays high for exactly NUM_CARDS consecutive cycles.
- Counter increments each enable cycle. cc_enable := 0 on the edge where counter reaches NUM_CARDS-1.
- Generator timing: after an edge where cc_enable was high, cc_address/cc_data is a valid pair, and cc_address is the target regfile address.
- valid_d := cc_enable, registered.
- valid_d high at an edge -> rf_we := 1, rf_waddr := cc_address, rf_wdata := cc_data.
- Net latency: loader write k (address k) is on rf outputs k+1 cycles after cc_enable first rises. Writes are back-to-back.
- Transition to HDR on the edge that registers the last card write.

HDR:
- One cycle: rf_we := 1, rf_waddr := 0, rf_wdata := NUM_CARDS/2 zero-extended to 14 bits.
- Then -> READY.

Timing summary, counting edge E0 as the one sampling new_game:
- cc_enable high after E0..E(N-1).
- Card writes after E2..E(N+1).
- Header write after E(N+2).
- board_ready=1 after E(N+3). For N=12 that is cycle 15.

Boundaries and arbitration:
- In LOAD and HDR, game_wr_ack=0. Requests stall without loss; the requester holds them.
- new_game while busy is ignored. No restart, and the write count stays NUM_CARDS+1.
- new_game and game_wr_req in the same READY cycle: both accepted. The game write is on rf after E0, ahead of loader writes, so there is no port collision.
- board_ready drops after E0.
- Loader writes never coincide with game writes. The port mux is state-driven, not priority-driven.
- cc_enable is never high outside LOAD.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> all outputs 0, game_wr_ack follows game_wr_req in IDLE.
- Full load (N=12): behavioural generator model, new_game pulse at E0.
  - cc_enable high for exactly 12 cycles.
  - rf_we high for 13 consecutive cycles after E2..E14.
  - Addresses 1..12 then 0; data matches model, with header 14'd6.
  - board_ready=1 from cycle 15.
- Stall: game_wr_req held high from cycle 3 -> game_wr_ack=0 through HDR. The first ack is in the first READY cycle, and its write is on rf the next cycle with no lost or duplicate loader writes.
- Collision in READY: new_game=1 and game_wr_req=1 (addr 4'h5, data 14'h3FFD) in the same cycle -> ack=1, rf write {5, 3FFD} after E0, then the normal load sequence starts at E2.
- Ignored restart: second new_game pulse at cycle 6 of a load -> exactly 13 writes total, board_ready at cycle 15 only.
- Reset mid-load: rst at cycle 7 -> cc_enable, rf_we and busy are 0 after that edge. A subsequent new_game produces a clean full 13-write sequence.
